// File: rtl/cim_readout_serializer.sv
// Captures a 192-bit CIM readout vector on a strobe and streams it as 32-bit beats over valid/ready.
// Back-to-back capture on the final beat avoids a bubble; captures while busy are dropped and flagged.
module cim_readout_serializer #(
  parameter int DATA_W = 192,
  parameter int WORD_W = 32,
  parameter int NWORDS = DATA_W / WORD_W,
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] q_in,
  input  logic              cap_en,
  input  logic [TAG_W-1:0]  cap_tag,
  output logic              cap_busy,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [TAG_W-1:0]  out_tag,
  output logic              ovf_err,
  input  logic              clr_err
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic [NWORDS-1:0][WORD_W-1:0]  buf_q, buf_d;
  logic [WORD_W-1:0]              out_data_q, out_data_d;
  logic [IDX_W-1:0]               out_idx_q, out_idx_d;
  logic [TAG_W-1:0]               out_tag_q, out_tag_d;
  logic                           out_valid_q, out_valid_d;
  logic                           ovf_q, ovf_d;
  logic                           transfer, accept, drop;
  logic [IDX_W-1:0]               idx_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (transfer && out_last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_last = out_valid_q && (out_idx_q == IDX_W'(NWORDS - 1));
    transfer = out_valid_q && out_ready;
    cap_busy = (state_q == SHIFT) && !(transfer && out_last);
    accept   = cap_en && !cap_busy;
    drop     = cap_en && cap_busy;
  end

  always_comb begin
    buf_d       = buf_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_tag_d   = out_tag_q;
    idx_inc     = out_idx_q + IDX_W'(1);
    if (accept) begin
      buf_d      = q_in;
      out_data_d = q_in[WORD_W-1:0];
      out_idx_d  = '0;
      out_tag_d  = cap_tag;
    end else if (transfer && !out_last) begin
      out_idx_d  = idx_inc;
      out_data_d = buf_q[idx_inc];
    end
    out_valid_d = (state_d == SHIFT);
    // Set has priority over clear so a drop coinciding with clr_err is never lost.
    if (drop)         ovf_d = 1'b1;
    else if (clr_err) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_tag   = out_tag_q;
  assign out_valid = out_valid_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_cim_readout_serializer.sv
// Directed and random stimulus for cim_readout_serializer, checked against a beat-queue reference model.
module tb_cim_readout_serializer;

  logic         clk;
  logic         rst;
  logic [191:0] q_in;
  logic         cap_en;
  logic [7:0]   cap_tag;
  logic         cap_busy;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_idx;
  logic         out_last;
  logic [7:0]   out_tag;
  logic         ovf_err;
  logic         clr_err;

  int checks = 0;
  int errors = 0;

  cim_readout_serializer dut (
    .clk(clk), .rst(rst), .q_in(q_in), .cap_en(cap_en), .cap_tag(cap_tag),
    .cap_busy(cap_busy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
    .out_tag(out_tag), .ovf_err(ovf_err), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of beats still owed to the consumer.
  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  idx;
    logic [7:0]  tag;
  } beat_t;

  beat_t exp_q[$];
  logic  m_ovf;
  logic  m_known = 1'b0;

  logic [191:0] vec_a, vec_b, vec_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_busy();
    return (exp_q.size() > 0) && !(out_ready && exp_q.size() == 1);
  endfunction

  task automatic check_all();
    chk("valid", 64'(out_valid), 64'(exp_q.size() > 0));
    chk("busy", 64'(cap_busy), 64'(model_busy()));
    chk("ovf", 64'(ovf_err), 64'(m_ovf));
    if (exp_q.size() > 0) begin
      chk("data", 64'(out_data), 64'(exp_q[0].d));
      chk("idx", 64'(out_idx), 64'(exp_q[0].idx));
      chk("tag", 64'(out_tag), 64'(exp_q[0].tag));
      chk("last", 64'(out_last), 64'(exp_q[0].idx == 3'd5));
    end else begin
      chk("last_idle", 64'(out_last), 64'd0);
    end
  endtask

  task automatic model_edge();
    logic busy;
    beat_t b;
    if (rst) begin
      exp_q.delete();
      m_ovf   = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      busy = model_busy();
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (cap_en && !busy) begin
        for (int w = 0; w < 6; w++) begin
          b.d   = q_in[w*32 +: 32];
          b.idx = 3'(w);
          b.tag = cap_tag;
          exp_q.push_back(b);
        end
      end
      if (cap_en && busy) m_ovf = 1'b1;
      else if (clr_err)   m_ovf = 1'b0;
    end
  endtask

  // Called at a negedge: drive inputs, check, update model, advance one cycle.
  task automatic step(input logic r, input logic ce, input logic [191:0] q,
                      input logic [7:0] t, input logic rdy, input logic clr);
    rst = r; cap_en = ce; q_in = q; cap_tag = t; out_ready = rdy; clr_err = clr;
    #1;
    if (m_known) check_all();
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, {6{$urandom()}}, 8'h00, rdy, 1'b0);
  endtask

  initial begin
    vec_a = {32'h66666666, 32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    vec_b = {32'hB5B5B5B5, 32'hB4B4B4B4, 32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hDEADBEEF};
    rst = 1'b1; cap_en = 1'b0; q_in = '0; cap_tag = '0; out_ready = 1'b0; clr_err = 1'b0;
    @(negedge clk);

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom()), {6{$urandom()}}, 8'($urandom()), 1'($urandom()), 1'($urandom()));
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    chk("rst_busy", 64'(cap_busy), 64'd0);
    idle(1'b1);

    // Streaming
    step(1'b0, 1'b1, vec_a, 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("strm_data", 64'(out_data), 64'(32'h11111111 * (i + 1)));
      chk("strm_idx", 64'(out_idx), 64'(i));
      chk("strm_last", 64'(out_last), 64'(i == 5));
      chk("strm_tag", 64'(out_tag), 64'h A5);
      idle(1'b1);
    end
    chk("strm_end_valid", 64'(out_valid), 64'd0);
    idle(1'b1);

    // Backpressure at idx 2
    step(1'b0, 1'b1, vec_a, 8'hA5, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("bp_data", 64'(out_data), 64'h33333333);
      chk("bp_idx", 64'(out_idx), 64'd2);
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    idle(1'b1);
    chk("bp_resume", 64'(out_data), 64'h44444444);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Overflow while beat 1 is presented
    step(1'b0, 1'b1, vec_a, 8'hA5, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b0, 1'b1, {192{1'b1}}, 8'hFF, 1'b0, 1'b0);
    chk("ovf_data", 64'(out_data), 64'h22222222);
    chk("ovf_set", 64'(ovf_err), 64'd1);
    step(1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b1);
    chk("ovf_clr", 64'(ovf_err), 64'd0);
    step(1'b0, 1'b1, {192{1'b1}}, 8'hFF, 1'b1, 1'b1);
    chk("ovf_set_wins", 64'(ovf_err), 64'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    step(1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b1);

    // Back-to-back capture on the last beat
    step(1'b0, 1'b1, vec_a, 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    step(1'b0, 1'b1, vec_b, 8'h3C, 1'b1, 1'b0);
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_idx", 64'(out_idx), 64'd0);
    chk("b2b_data", 64'(out_data), 64'hDEADBEEF);
    chk("b2b_tag", 64'(out_tag), 64'h3C);
    chk("b2b_busy", 64'(cap_busy), 64'd1);
    chk("b2b_ovf", 64'(ovf_err), 64'd0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Mid-stream reset at idx 3
    step(1'b0, 1'b1, vec_b, 8'h3C, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("mrst_pre_idx", 64'(out_idx), 64'd3);
    step(1'b1, 1'b0, '0, 8'h00, 1'b1, 1'b0);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_idx", 64'(out_idx), 64'd0);
    step(1'b0, 1'b1, vec_a, 8'h77, 1'b1, 1'b0);
    chk("mrst_new_data", 64'(out_data), 64'h11111111);
    chk("mrst_new_tag", 64'(out_tag), 64'h77);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      vec_r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), vec_r,
           8'($urandom()), ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
